// File: rtl/switch_pkg.sv
// Shared switch constants: channel count and debounce window for the 50 MHz board clock.
package switch_pkg;

  localparam int SW_WIDTH           = 4;
  localparam int CLK_HZ             = 50_000_000;
  localparam int DEBOUNCE_MS        = 10;
  localparam int SW_DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-FF synchronizer, stability counter, registered output level.
// SWITCH_DEBOUNCER_STATUS_EN adds a registered busy flag (channel is settling).
module switch_debounce_ch
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o
`ifdef SWITCH_DEBOUNCER_STATUS_EN
  ,
  output logic busy_o
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             sw_q;
  logic             sw_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter is non-zero only while the synchronized level disagrees with the output.
  always_comb begin
    sw_d  = sw_q;
    cnt_d = '0;
    if (sync2_q != sw_q) begin
      if (cnt_q == CNT_LAST) begin
        sw_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o = sw_q;

`ifdef SWITCH_DEBOUNCER_STATUS_EN
  logic busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch synchronizer/debouncer feeding the one-shot stage.
// SWITCH_DEBOUNCER_STATUS_EN adds sw_busy/sw_any_busy settling indicators.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out
`ifdef SWITCH_DEBOUNCER_STATUS_EN
  ,
  output logic [WIDTH-1:0] sw_busy,
  output logic             sw_any_busy
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i (CLK50MHZ),
      .rst_i (RST),
      .sw_i  (sw_in[i]),
      .sw_o  (sw_out[i])
`ifdef SWITCH_DEBOUNCER_STATUS_EN
      ,
      .busy_o(sw_busy[i])
`endif
    );
  end

`ifdef SWITCH_DEBOUNCER_STATUS_EN
  assign sw_any_busy = |sw_busy;
`endif

endmodule
